// File: rtl/wb_sequencer.sv
// wb_sequencer: writeback stage selecting per-opcode results, sequencing register writes (incl. two-write SWAP), flags and TRAP halt
module wb_sequencer #(
  parameter int DW = 20,
  parameter int AW = 4,
  parameter int NOPS = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        opcode,
  input  logic [NOPS*DW-1:0] w_bus,
  input  logic [DW-1:0]     op_a,
  input  logic [DW-1:0]     op_b,
  input  logic [AW-1:0]     dest_a,
  input  logic [AW-1:0]     dest_b,
  input  logic [3:0]        path_carry,
  input  logic [2:0]        path_cmp,
  output logic              rf_we,
  output logic [AW-1:0]     rf_waddr,
  output logic [DW-1:0]     rf_wdata,
  output logic              flag_c,
  output logic              flag_z,
  output logic              flag_s,
  output logic              halted,
  output logic              illegal_op
);
  typedef enum logic [1:0] {IDLE, WB1, WB2, HALT} state_t;
  state_t state, next;
  logic accept, is_write, is_swap, is_trap, is_ill, carry_bit, swap_pend;
  logic [DW-1:0] w_sel, swap_data;
  logic [AW-1:0] swap_dest;
  assign in_ready = state == IDLE;
  assign halted = state == HALT;
  assign accept = in_valid && in_ready;
  assign w_sel = w_bus[DW*opcode +: DW];
  always_comb begin
    is_write = opcode inside {[5'd8:5'd15], [5'd17:5'd19], 5'd21};
    is_ill = opcode inside {[5'd3:5'd7], 5'd20, [5'd25:5'd31]};
    is_swap = opcode == 5'd16;
    is_trap = opcode == 5'd0;
    carry_bit = opcode == 5'd17 ? path_carry[0] :
                opcode == 5'd18 ? path_carry[1] :
                opcode == 5'd19 ? path_carry[2] :
                opcode == 5'd21 ? path_carry[3] : 1'b0;
  end
  always_ff @(posedge clk) state <= rst ? IDLE : next;
  always_comb begin
    next = state;
    next = state == IDLE ? (!accept ? IDLE : is_trap ? HALT : (is_write || is_swap) ? WB1 : IDLE) :
           state == WB1  ? (swap_pend ? WB2 : IDLE) :
           state == WB2  ? IDLE : HALT;
  end
  // write port is registered: the accept edge loads the first write so it appears during WB1
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      flag_c <= 1'b0;
      flag_z <= 1'b0;
      flag_s <= 1'b0;
      illegal_op <= 1'b0;
      swap_pend <= 1'b0;
      swap_data <= '0;
      swap_dest <= '0;
    end else begin
      rf_we <= 1'b0;
      illegal_op <= accept && is_ill;
      if (accept && is_write) begin
        rf_we <= 1'b1;
        rf_waddr <= dest_a;
        rf_wdata <= w_sel;
        flag_z <= w_sel == '0;
        flag_c <= carry_bit;
        flag_s <= w_sel[DW-1];
      end
      if (accept && is_swap) begin
        rf_we <= 1'b1;
        rf_waddr <= dest_a;
        rf_wdata <= op_b;
        swap_data <= op_a;
        swap_dest <= dest_b;
        swap_pend <= 1'b1;
      end
      if (accept && opcode == 5'd22) flag_z <= path_cmp[0];
      if (accept && opcode == 5'd23) flag_s <= path_cmp[1];
      if (accept && opcode == 5'd24) flag_s <= path_cmp[2];
      if (state == WB1 && swap_pend) begin
        rf_we <= 1'b1;
        rf_waddr <= swap_dest;
        rf_wdata <= swap_data;
        swap_pend <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_wb_sequencer.sv
// tb_wb_sequencer: table vectors plus hand sequences; register writes checked against a scoreboard queue
module tb_wb_sequencer;
  logic clk = 0, rst = 1, in_valid = 0, in_ready;
  logic [4:0] opcode = 0;
  logic [639:0] w_bus = '0;
  logic [19:0] op_a = 0, op_b = 0, rf_wdata;
  logic [3:0] dest_a = 0, dest_b = 0, path_carry = 0, rf_waddr;
  logic [2:0] path_cmp = 0;
  logic rf_we, flag_c, flag_z, flag_s, halted, illegal_op;
  int total = 0, bad = 0;
  logic [23:0] sb[$];
  typedef struct {
    logic [4:0] op; logic [19:0] w; logic [3:0] car; logic [2:0] cmp; logic [3:0] dst;
    logic wr; logic c; logic z; logic s; logic ill;
  } vec_t;
  vec_t v[13];
  logic [2:0] cmps[3];
  wb_sequencer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .opcode(opcode),
    .w_bus(w_bus), .op_a(op_a), .op_b(op_b), .dest_a(dest_a), .dest_b(dest_b),
    .path_carry(path_carry), .path_cmp(path_cmp), .rf_we(rf_we), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .flag_c(flag_c), .flag_z(flag_z), .flag_s(flag_s),
    .halted(halted), .illegal_op(illegal_op)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  always @(negedge clk) if (rf_we) begin
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL stray_write: got we=1 addr=%h data=%h expected no write", rf_waddr, rf_wdata);
    end else chk("write", {8'h0, rf_waddr, rf_wdata}, {8'h0, sb.pop_front()});
  end
  task automatic send(input logic [4:0] op, input logic [19:0] w, input logic [3:0] car, input logic [2:0] cmp,
                      input logic [3:0] da, input logic [3:0] db, input logic [19:0] a, input logic [19:0] b);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("ready_timeout", 0, 1);
    for (int i = 0; i < 32; i++) w_bus[i*20 +: 20] = 20'($urandom);
    w_bus[int'(op)*20 +: 20] = w;
    opcode = op; path_carry = car; path_cmp = cmp; dest_a = da; dest_b = db; op_a = a; op_b = b;
    in_valid = 1;
    @(posedge clk);
    #1 in_valid = 0;
  endtask
  task automatic chk_flags(input string nm, input logic c, input logic z, input logic s);
    chk(nm, {flag_c, flag_z, flag_s}, {c, z, s});
  endtask
  initial begin
    v[0]  = '{5'd19, 20'h0000F, 4'b0100, 3'b000, 4'd3,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    v[1]  = '{5'd21, 20'h00000, 4'b0000, 3'b000, 4'd5,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    v[2]  = '{5'd8,  20'h80001, 4'b1111, 3'b000, 4'd7,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    v[3]  = '{5'd17, 20'h00010, 4'b0001, 3'b000, 4'd2,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    v[4]  = '{5'd18, 20'hFFFFF, 4'b1101, 3'b000, 4'd9,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    v[5]  = '{5'd22, 20'h00000, 4'b0000, 3'b001, 4'd0,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    v[6]  = '{5'd23, 20'h00000, 4'b0000, 3'b000, 4'd0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    v[7]  = '{5'd1,  20'h00000, 4'b1111, 3'b111, 4'd0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    v[8]  = '{5'd20, 20'h00000, 4'b1111, 3'b111, 4'd0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    v[9]  = '{5'd24, 20'h00000, 4'b0000, 3'b100, 4'd0,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    v[10] = '{5'd15, 20'h00000, 4'b1111, 3'b000, 4'd15, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    v[11] = '{5'd2,  20'h00000, 4'b1111, 3'b111, 4'd0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    v[12] = '{5'd21, 20'h12345, 4'b1000, 3'b000, 4'd4,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    cmps = '{3'b001, 3'b000, 3'b100};
    repeat (2) @(posedge clk);
    #1 rst = 0;
    chk("rst_ready", in_ready, 1);
    chk("rst_port", {rf_we, rf_waddr, rf_wdata}, 0);
    chk_flags("rst_flags", 0, 0, 0);
    chk("rst_halt_ill", {halted, illegal_op}, 0);
    foreach (v[i]) begin
      if (v[i].wr) sb.push_back({v[i].dst, v[i].w});
      send(v[i].op, v[i].w, v[i].car, v[i].cmp, v[i].dst, 4'd0, 20'h0, 20'h0);
      chk_flags($sformatf("vec%0d_flags", i), v[i].c, v[i].z, v[i].s);
      chk($sformatf("vec%0d_ill", i), illegal_op, v[i].ill);
      chk($sformatf("vec%0d_ready", i), in_ready, !v[i].wr);
    end
    sb.push_back({4'd1, 20'h55555});
    sb.push_back({4'd2, 20'hAAAAA});
    send(5'd16, 20'h0, 4'b0000, 3'b000, 4'd1, 4'd2, 20'hAAAAA, 20'h55555);
    chk("swap_ready1", in_ready, 0);
    @(posedge clk); #1 chk("swap_ready2", in_ready, 0);
    @(posedge clk); #1 chk("swap_ready3", in_ready, 1);
    chk_flags("swap_flags", 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("b2b_ready", in_ready, 1);
      opcode = 5'(22 + i); path_cmp = cmps[i]; in_valid = 1;
    end
    @(posedge clk);
    #1 in_valid = 0;
    chk_flags("b2b_flags", 1, 1, 1);
    sb.push_back({4'd6, 20'h0BEEF});
    sb.push_back({4'd6, 20'h0CAFE});
    send(5'd16, 20'h0, 4'b0000, 3'b000, 4'd6, 4'd6, 20'h0CAFE, 20'h0BEEF);
    send(5'd25, 20'h0, 4'b0000, 3'b000, 4'd0, 4'd0, 20'h0, 20'h0);
    chk("ill25_pulse", illegal_op, 1);
    @(posedge clk); #1 chk("ill25_clear", illegal_op, 0);
    send(5'd0, 20'h0, 4'b0000, 3'b000, 4'd0, 4'd0, 20'h0, 20'h0);
    chk("trap_halt", {halted, in_ready}, 2'b10);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("halt_ready", in_ready, 0);
      w_bus[19*20 +: 20] = 20'h00001; opcode = 5'd19; dest_a = 4'd11; path_carry = 4'b0000; in_valid = 1;
    end
    @(negedge clk);
    in_valid = 0;
    chk("halt_stays", halted, 1);
    chk_flags("halt_flags", 1, 1, 1);
    rst = 1;
    @(posedge clk);
    #1 rst = 0;
    chk("hrst_ready", {in_ready, halted, illegal_op}, 3'b100);
    chk("hrst_port", {rf_we, rf_waddr, rf_wdata}, 0);
    chk_flags("hrst_flags", 0, 0, 0);
    sb.push_back({4'd8, 20'h22222});
    send(5'd16, 20'h0, 4'b0000, 3'b000, 4'd8, 4'd9, 20'h11111, 20'h22222);
    @(negedge clk);
    #1 rst = 1;
    @(posedge clk);
    #1 rst = 0;
    chk("wb1rst_port", {rf_we, rf_waddr, rf_wdata}, 0);
    chk("wb1rst_ready", in_ready, 1);
    repeat (3) @(posedge clk);
    #1 chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/wb_sequencer.md
Name: wb_sequencer

Overview:
- Writeback stage directly downstream of the per-opcode operation paths. It consumes the 32-entry result bus (W[0..31]) plus the carry and compare outputs of those paths.
- Selects the result for the issued opcode and sequences register-file writes, including the two-write SWAP (opcode 16).
- Maintains the architectural C/Z/S flag register and the TRAP halt state.
- Single-issue, valid/ready handshake toward the issue stage.

Parameters:
- DW, 20, datapath width (one W entry).
- AW, 4, register-file address width.
- NOPS, 32, number of opcode paths on the result bus.

Ports:
- clk  input  1  system clock
- rst  input  1  reset, synchronous, active-high
- in_valid  input  1  issue stage presents an instruction
- in_ready  output  1  stage can accept (IDLE only)
- opcode  input  5  opcode of the presented instruction
- w_bus  input  NOPS*DW  flattened result bus; W[i] = w_bus[DW*i+DW-1 : DW*i]
- op_a  input  DW  source operand A (used by SWAP)
- op_b  input  DW  source operand B (used by SWAP)
- dest_a  input  AW  primary destination register
- dest_b  input  AW  second destination (SWAP only)
- path_carry  input  4  carry-outs, bit0 INC, bit1 DEC, bit2 ADD, bit3 SUB
- path_cmp  input  3  compare results, bit0 EQ, bit1 GT, bit2 LT
- rf_we  output  1  register-file write enable
- rf_waddr  output  AW  write address
- rf_wdata  output  DW  write data
- flag_c, flag_z, flag_s  output  1 each  flag register
- halted  output  1  TRAP executed
- illegal_op  output  1  one-cycle pulse on an unimplemented opcode

Behaviour:
- Reset: state=IDLE. in_ready=1. rf_we=0, rf_waddr=0, rf_wdata=0. All flags 0. halted=0. illegal_op=0.
- States: IDLE, WB1, WB2, HALT. Accept = in_valid && in_ready at a rising edge. in_ready=1 only in IDLE.
- On accept, opcode class and behaviour:
  - Write ops {8,9,10,11,12,13,14,15,17,18,19,21}: latch W[opcode] and dest_a; go to WB1. Flags are updated at this same edge.
    - flag_z = (W[opcode]==0).
    - flag_c = matching path_carry bit for 17/18/19/21; cleared for the other write ops.
    - flag_s = W[opcode][DW-1].
  - SWAP (16): latch op_a, op_b, dest_a, dest_b; go to WB1. Flags unchanged.
  - Compare ops, no write, stay IDLE: 22 sets flag_z=path_cmp[0]; 23 sets flag_s=path_cmp[1]; 24 sets flag_s=path_cmp[2]. Other flags unchanged.
  - NOP (1), JMP (2): no write, no flag change, stay IDLE.
  - TRAP (0): go to HALT; halted=1 from the next cycle.
  - Unimplemented {3-7, 20, 25-31}: treated as NOP; illegal_op=1 for exactly the cycle after the accept.
- WB1 (one cycle): rf_we=1.
  - Non-SWAP: rf_waddr = latched dest, rf_wdata = latched W; go to IDLE.
  - SWAP: rf_waddr=dest_a, rf_wdata=op_b; go to WB2.
- WB2 (one cycle): rf_we=1, rf_waddr=dest_b, rf_wdata=op_a; go to IDLE.
  - If dest_a==dest_b, the final register value is op_a (last write wins).
- Latency and throughput:
  - Write-op result is visible on the write port exactly 1 cycle after accept.
  - Write ops accept at most one instruction per 2 cycles; SWAP, one per 3 cycles.
  - Compare and NOP ops accept back-to-back every cycle.
- rf_we is registered and driven 0 outside WB1/WB2. rf_waddr and rf_wdata hold their last values when rf_we=0.
- HALT: in_ready=0, no writes, flags frozen. Only rst exits.
- rst asserted in any state, including between WB1 and WB2: return to the reset values on the next edge. A pending second SWAP write is dropped.
- Inputs are sampled only at the accept edge; changes to inputs during WB1/WB2 have no effect.

Test Plan:
- ADD, opcode 19, W[19]=20'h0000F, path_carry=4'b0100, dest_a=3 -> the next cycle shows rf_we=1, waddr=3, wdata=20'h0000F; flag_c=1, flag_z=0, flag_s=0; in_ready returns to 1 one cycle later.
- SWAP with op_a=20'hAAAAA, op_b=20'h55555, dest_a=1, dest_b=2 -> cycle+1: write reg1=20'h55555; cycle+2: write reg2=20'hAAAAA; in_ready=0 for 2 cycles.
- EQ, then GT, then LT presented back-to-back with path_cmp=3'b001, 3'b000, 3'b100 -> three accepts in 3 cycles; rf_we stays 0; final flag_z=1, flag_s=1.
- SUB with W[21]=0 and path_carry[3]=0 -> flag_z=1, flag_c=0, write of 0 to dest_a.
- Opcode 25 -> illegal_op pulses for 1 cycle, no write. Then TRAP -> halted=1 and in_ready=0; a following in_valid is ignored until rst, after which all outputs are at reset values.
- Assert rst during the WB1 cycle of a SWAP -> no WB2 write occurs; the next cycle is IDLE with rf_we=0.
